// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and round-robin helper for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    // First set bit of mask strictly after ptr, wrapping modulo n; ptr itself is checked last.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX_REQ-1:0] mask,
        input int unsigned           ptr,
        input int unsigned           n
    );
        logic                hit;
        logic [RR_IDX_W-1:0] idx;
        rr_next = '0;
        hit     = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
            idx = RR_IDX_W'((ptr + k) % n);
            if (k <= n && !hit && mask[idx]) begin
                rr_next = idx;
                hit     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer and FIFO write-side signals of the arbiter
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_full;
    logic                          fifo_overflow;

    // master: producers plus FIFO status; slave: the arbiter
    modport master (
        output req_valid, req_last, req_data, fifo_full, fifo_overflow,
        input  req_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full, fifo_overflow,
        output req_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational rotating-priority picker
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    assign found = |valid;
    assign index = IDX_W'(rr_next(RR_MAX_REQ'(valid), 32'(ptr), 32'(NUM_REQ)));

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 4,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_write_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_W-1:0]     owner_id,
    output logic                 err_overflow
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t           state, state_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic [IDX_W-1:0]     owner_n;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]     beat_cnt, beat_cnt_n;
    logic [IDX_W-1:0]     pick_ptr, pick_idx;
    logic                 pick_found;
    logic                 owner_valid, owner_last, accept, at_limit, release_now;
    logic [NUM_REQ-1:0]   ready_v;
    logic                 wr_en_v;

    assign owner_valid = |(bus.req_valid & grant);
    assign owner_last  = |(bus.req_last & grant);
    assign accept      = wr_en_v;
    assign at_limit    = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign release_now = (state == ARB_BURST) &&
                         (!owner_valid || (accept && (owner_last || at_limit)));

    // Searching from the owner's index puts it last in line, so it only
    // re-wins when no other producer is valid.
    assign pick_ptr = (state == ARB_BURST) ? owner_id : rr_ptr;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            grant        <= '0;
            owner_id     <= '0;
            beat_cnt     <= '0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            err_overflow <= 1'b0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            owner_id     <= owner_n;
            beat_cnt     <= beat_cnt_n;
            rr_ptr       <= rr_ptr_n;
            err_overflow <= err_overflow | bus.fifo_overflow;
        end
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        owner_n    = owner_id;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_n    = ARB_BURST;
                    grant_n    = NUM_REQ'(1) << pick_idx;
                    owner_n    = pick_idx;
                    beat_cnt_n = '0;
                end
            end
            ARB_BURST: begin
                if (release_now) begin
                    rr_ptr_n   = owner_id;
                    beat_cnt_n = '0;
                    if (pick_found) begin
                        grant_n = NUM_REQ'(1) << pick_idx;
                        owner_n = pick_idx;
                    end else begin
                        state_n = ARB_IDLE;
                        grant_n = '0;
                    end
                end else if (accept) begin
                    beat_cnt_n = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ARB_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_comb begin
        ready_v          = grant & {NUM_REQ{~bus.fifo_full}};
        wr_en_v          = |(bus.req_valid & ready_v);
        bus.req_ready    = ready_v;
        bus.fifo_wr_en   = wr_en_v;
        bus.fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_en_v && owner_id == IDX_W'(i)) begin
                bus.fifo_wr_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] grant;
    logic [1:0] owner_id;
    logic       err_overflow;

    logic        model_en;
    logic        fifo_rd;
    logic [3:0]  fcnt;
    logic [23:0] seq [NR];

    int n_checks = 0;
    int n_fail   = 0;

    fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .grant        (grant),
        .owner_id     (owner_id),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // Producer i offers {i, running beat number}; the number advances on each accepted beat.
    for (genvar i = 0; i < NR; i++) begin : g_data
        assign bus.req_data[i*DW +: DW] = {8'(i), seq[i]};
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (reset) seq[i] <= '0;
            else if (bus.req_valid[i] && bus.req_ready[i]) seq[i] <= seq[i] + 24'd1;
        end
    end

    // Eight-entry FIFO occupancy model driving full_flag.
    always @(posedge clk) begin
        if (!model_en) fcnt <= '0;
        else           fcnt <= fcnt + {3'b0, bus.fifo_wr_en} - {3'b0, fifo_rd};
    end
    assign bus.fifo_full = model_en && (fcnt == 4'd8);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        model_en          = 1'b0;
        fifo_rd           = 1'b0;
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.fifo_overflow = 1'b0;
        do_reset();

        settle();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_owner", 64'(owner_id), 64'h0);
        check("rst_wr_en", 64'(bus.fifo_wr_en), 64'h0);
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_err", 64'(err_overflow), 64'h0);

        // Single producer, three-beat packet.
        bus.req_valid = 4'b0001;
        settle();
        check("t1_latency_grant", 64'(grant), 64'h0);
        tick();
        check("t1_grant", 64'(grant), 64'h1);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.req_last = 4'b0001;
            settle();
            check("t1_wr_en", 64'(bus.fifo_wr_en), 64'h1);
            check("t1_data", 64'(bus.fifo_wr_data), 64'(k));
            tick();
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        settle();
        check("t1_no_4th_write", 64'(bus.fifo_wr_en), 64'h0);
        tick();
        check("t1_idle_grant", 64'(grant), 64'h0);

        // All producers streaming, never last: bursts of exactly four.
        do_reset();
        bus.req_valid = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                logic [3:0]  eg;
                logic [31:0] ed;
                eg = 4'b0001 << (g % 4);
                ed = {8'(g % 4), 24'((g / 4) * 4 + b)};
                settle();
                check("t2_grant", 64'(grant), 64'(eg));
                check("t2_data", 64'(bus.fifo_wr_data), 64'(ed));
                tick();
            end
        end
        check("t2_next_grant", 64'(grant), 64'h2);
        bus.req_valid = '0;
        tick();
        check("t2_idle_grant", 64'(grant), 64'h0);
        check("t2_owner_hold", 64'(owner_id), 64'h1);

        // Owner 2 fills an eight-entry FIFO, then one read frees one slot.
        do_reset();
        model_en      = 1'b1;
        bus.req_valid = 4'b0100;
        tick();
        check("t3_grant", 64'(grant), 64'h4);
        for (int k = 0; k < 8; k++) begin
            settle();
            check("t3_fill_wr_en", 64'(bus.fifo_wr_en), 64'h1);
            check("t3_fill_data", 64'(bus.fifo_wr_data), 64'({8'd2, 24'(k)}));
            tick();
        end
        check("t3_full_ready", 64'(bus.req_ready), 64'h0);
        check("t3_full_wr_en", 64'(bus.fifo_wr_en), 64'h0);
        check("t3_full_data", 64'(bus.fifo_wr_data), 64'h0);
        tick();
        check("t3_stall_grant", 64'(grant), 64'h4);
        check("t3_stall_wr_en", 64'(bus.fifo_wr_en), 64'h0);
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        settle();
        check("t3_resume_wr_en", 64'(bus.fifo_wr_en), 64'h1);
        check("t3_resume_ready", 64'(bus.req_ready), 64'h4);
        check("t3_resume_data", 64'(bus.fifo_wr_data), 64'h0200_0008);
        tick();
        check("t3_refull_wr_en", 64'(bus.fifo_wr_en), 64'h0);
        check("t3_refull_grant", 64'(grant), 64'h4);
        model_en      = 1'b0;
        bus.req_valid = '0;

        // Owner 1 drops valid mid-burst while producer 3 waits.
        do_reset();
        bus.req_valid = 4'b1010;
        tick();
        check("t4_first_grant", 64'(grant), 64'h2);
        tick();
        bus.req_valid = 4'b1000;
        settle();
        check("t4_drop_wr_en", 64'(bus.fifo_wr_en), 64'h0);
        tick();
        check("t4_handoff_grant", 64'(grant), 64'h8);
        check("t4_handoff_owner", 64'(owner_id), 64'h3);
        check("t4_handoff_ready", 64'(bus.req_ready), 64'h8);

        // Reset in the middle of a burst after two beats.
        do_reset();
        bus.req_valid = 4'b1111;
        tick();
        tick();
        tick();
        check("t5_mid_grant", 64'(grant), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_grant", 64'(grant), 64'h0);
        check("t5_rst_wr_en", 64'(bus.fifo_wr_en), 64'h0);
        check("t5_rst_owner", 64'(owner_id), 64'h0);
        tick();
        check("t5_regrant", 64'(grant), 64'h1);
        bus.req_valid = '0;

        // Sticky overflow error.
        tick();
        check("t6_err_before", 64'(err_overflow), 64'h0);
        bus.fifo_overflow = 1'b1;
        tick();
        bus.fifo_overflow = 1'b0;
        check("t6_err_set", 64'(err_overflow), 64'h1);
        tick();
        tick();
        tick();
        check("t6_err_sticky", 64'(err_overflow), 64'h1);
        do_reset();
        check("t6_err_cleared", 64'(err_overflow), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
